// File: rtl/m_seq_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : m_seq_pkg                                                  |
// | Purpose : Types and default constants shared by the m-sequence       |
// |           receiver and its matching generator.                       |
// | Revision: 1.0  initial release                                       |
// +----------------------------------------------------------------------+
package m_seq_pkg;

   // Receiver acquisition states
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_FILL   = 2'd1,
      ST_VERIFY = 2'd2,
      ST_LOCK   = 2'd3
   } state_t;

   // x^6 + x + 1, feedback taps without the leading "1"
   localparam logic [5:0] DEFAULT_POLYNOME = 6'b000011;
   // Sequence length in chips for the default polynomial
   localparam int         DEFAULT_N        = 63;

endpackage : m_seq_pkg
`default_nettype wire

// File: rtl/m_seq_chip_slicer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : m_seq_chip_slicer                                          |
// | Purpose : Cuts the oversampled input into HOLD-cycle windows and     |
// |           decides each chip by majority vote.                        |
// | Ports   : clkin          - clock                                     |
// |           rst            - asynchronous active-high reset            |
// |           valid_i        - stream present; low restarts the window   |
// |           din            - oversampled chip stream                   |
// |           chip_o         - last decided chip (held while idle)       |
// |           chip_strobe_o  - one-cycle pulse when chip_o updates       |
// | Revision: 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module m_seq_chip_slicer #(
   parameter int HOLD = 3
) (
   input  logic clkin,
   input  logic rst,
   input  logic valid_i,
   input  logic din,
   output logic chip_o,
   output logic chip_strobe_o
);

   localparam int C_CNT_W = $clog2(HOLD + 1);

   logic [C_CNT_W-1:0] cnt_q, cnt_d;
   logic [C_CNT_W-1:0] ones_q, ones_d;
   logic               chip_q, chip_d;
   logic               strobe_q, strobe_d;
   logic [C_CNT_W-1:0] w_ones_total;

   always_comb begin
      // Include the current sample so the decision lands on the last cycle
      w_ones_total = ones_q + C_CNT_W'(din);
      cnt_d        = cnt_q;
      ones_d       = ones_q;
      chip_d       = chip_q;
      strobe_d     = 1'b0;
      if (!valid_i) begin
         // Window restarts on the first valid cycle; chip keeps last value
         cnt_d  = '0;
         ones_d = '0;
      end else if (cnt_q == C_CNT_W'(HOLD - 1)) begin
         cnt_d    = '0;
         ones_d   = '0;
         chip_d   = (w_ones_total > C_CNT_W'(HOLD / 2));
         strobe_d = 1'b1;
      end else begin
         cnt_d  = cnt_q + C_CNT_W'(1);
         ones_d = w_ones_total;
      end
   end

   always_ff @(posedge clkin or posedge rst) begin
      if (rst) begin
         cnt_q    <= '0;
         ones_q   <= '0;
         chip_q   <= 1'b0;
         strobe_q <= 1'b0;
      end else begin
         cnt_q    <= cnt_d;
         ones_q   <= ones_d;
         chip_q   <= chip_d;
         strobe_q <= strobe_d;
      end
   end

   assign chip_o        = chip_q;
   assign chip_strobe_o = strobe_q;

endmodule : m_seq_chip_slicer
`default_nettype wire

// File: rtl/m_sequence_rx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : m_sequence_rx                                              |
// | Purpose : Acquires and tracks an m-sequence: fills an LFSR window    |
// |           from received chips, verifies predictions, then            |
// |           flywheels on the local LFSR while locked.                  |
// | Ports   : clkin          - clock                                     |
// |           rst            - asynchronous active-high reset            |
// |           valid_i        - incoming chip stream present              |
// |           din            - received chips, each held HOLD cycles     |
// |           chip_o         - majority-decided chip                     |
// |           chip_strobe_o  - pulse when chip_o updates                 |
// |           lock_o         - high while locked                         |
// |           phase_o        - current LFSR window                       |
// |           err_o          - pulse on a misprediction (VERIFY/LOCK)    |
// | Revision: 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module m_sequence_rx
   import m_seq_pkg::*;
#(
   parameter int                N        = DEFAULT_N,
   parameter int                LENGTH   = $clog2(N),
   parameter logic [LENGTH-1:0] POLYNOME = LENGTH'(DEFAULT_POLYNOME),
   parameter int                HOLD     = 3,
   parameter int                CONFIRM  = 8,
   parameter int                ERR_MAX  = 3
) (
   input  logic              clkin,
   input  logic              rst,
   input  logic              valid_i,
   input  logic              din,
   output logic              chip_o,
   output logic              chip_strobe_o,
   output logic              lock_o,
   output logic [LENGTH-1:0] phase_o,
   output logic              err_o
);

   localparam int C_FILL_W  = $clog2(LENGTH + 1);
   localparam int C_MATCH_W = $clog2(CONFIRM + 1);
   localparam int C_ERR_W   = $clog2(ERR_MAX + 1);

   state_t                 state_q, state_d;
   logic [LENGTH-1:0]      r_q, r_d;
   logic [C_FILL_W-1:0]    fill_q, fill_d;
   logic [C_MATCH_W-1:0]   match_q, match_d;
   logic [C_ERR_W-1:0]     errc_q, errc_d;
   logic                   err_q, err_d;
   logic                   w_pred;
   logic [LENGTH-1:0]      w_r_rx;

   m_seq_chip_slicer #(
      .HOLD (HOLD)
   ) u_slicer (
      .clkin         (clkin),
      .rst           (rst),
      .valid_i       (valid_i),
      .din           (din),
      .chip_o        (chip_o),
      .chip_strobe_o (chip_strobe_o)
   );

   always_comb begin
      w_pred  = ^(POLYNOME & r_q);
      w_r_rx  = {chip_o, r_q[LENGTH-1:1]};
      state_d = state_q;
      r_d     = r_q;
      fill_d  = fill_q;
      match_d = match_q;
      errc_d  = errc_q;
      err_d   = 1'b0;
      if (!valid_i) begin
         state_d = ST_IDLE;
         fill_d  = '0;
         match_d = '0;
         errc_d  = '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               state_d = ST_FILL;
               fill_d  = '0;
            end
            ST_FILL: begin
               if (chip_strobe_o) begin
                  r_d = w_r_rx;
                  if (fill_q == C_FILL_W'(LENGTH - 1)) begin
                     fill_d = '0;
                     // All-zero window is the LFSR lock-up state: refill
                     if (w_r_rx != '0) begin
                        state_d = ST_VERIFY;
                        match_d = '0;
                     end
                  end else begin
                     fill_d = fill_q + C_FILL_W'(1);
                  end
               end
            end
            ST_VERIFY: begin
               if (chip_strobe_o) begin
                  r_d = w_r_rx;
                  if (chip_o == w_pred) begin
                     if (match_q == C_MATCH_W'(CONFIRM - 1)) begin
                        state_d = ST_LOCK;
                        match_d = '0;
                        errc_d  = '0;
                     end else begin
                        match_d = match_q + C_MATCH_W'(1);
                     end
                  end else begin
                     err_d   = 1'b1;
                     state_d = ST_FILL;
                     fill_d  = '0;
                     match_d = '0;
                  end
               end
            end
            ST_LOCK: begin
               if (chip_strobe_o) begin
                  // Flywheel: the local prediction drives the window
                  r_d = {w_pred, r_q[LENGTH-1:1]};
                  if (chip_o != w_pred) begin
                     err_d = 1'b1;
                     if (errc_q == C_ERR_W'(ERR_MAX - 1)) begin
                        state_d = ST_FILL;
                        fill_d  = '0;
                        errc_d  = '0;
                     end else begin
                        errc_d = errc_q + C_ERR_W'(1);
                     end
                  end else begin
                     errc_d = '0;
                  end
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clkin or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         r_q     <= '0;
         fill_q  <= '0;
         match_q <= '0;
         errc_q  <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         r_q     <= r_d;
         fill_q  <= fill_d;
         match_q <= match_d;
         errc_q  <= errc_d;
         err_q   <= err_d;
      end
   end

   assign lock_o  = (state_q == ST_LOCK);
   assign phase_o = r_q;
   assign err_o   = err_q;

endmodule : m_sequence_rx
`default_nettype wire

// File: tb/tb_m_sequence_rx.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_m_sequence_rx                                           |
// | Purpose : Scoreboard bench for m_sequence_rx with default            |
// |           parameters (x^6+x+1, HOLD=3, CONFIRM=8, ERR_MAX=3).        |
// | Revision: 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module tb_m_sequence_rx;

   localparam int HOLD = 3;

   logic       clkin = 1'b0;
   logic       rst;
   logic       valid_i;
   logic       din;
   logic       chip_o;
   logic       chip_strobe_o;
   logic       lock_o;
   logic [5:0] phase_o;
   logic       err_o;

   always #5 clkin = ~clkin;

   m_sequence_rx #(
      .N        (63),
      .LENGTH   (6),
      .POLYNOME (6'b000011),
      .HOLD     (HOLD),
      .CONFIRM  (8),
      .ERR_MAX  (3)
   ) dut (
      .clkin         (clkin),
      .rst           (rst),
      .valid_i       (valid_i),
      .din           (din),
      .chip_o        (chip_o),
      .chip_strobe_o (chip_strobe_o),
      .lock_o        (lock_o),
      .phase_o       (phase_o),
      .err_o         (err_o)
   );

   int         n_cmp    = 0;
   int         n_bad    = 0;
   int         err_seen = 0;
   logic       exp_q[$];
   // Reference generator: emits bit 0, feeds back bit0 ^ bit1 at the top
   logic [5:0] gen_r     = 6'b101010;
   logic [5:0] hist      = 6'b0;
   logic [5:0] prev_hist = 6'b0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Scoreboard side: every chip strobe pops one expected decision
   always @(negedge clkin) begin
      if (err_o) err_seen++;
      if (chip_strobe_o) begin
         if (exp_q.size() == 0) chk("strobe_unexpected", 32'd1, 32'd0);
         else chk("chip", {31'b0, chip_o}, {31'b0, exp_q.pop_front()});
      end
   end

   // Sends the next generator chip; invert corrupts the whole chip,
   // glitch flips only the middle sample.
   task automatic send_chip(input bit invert, input bit glitch);
      logic c;
      c         = gen_r[0];
      gen_r     = {gen_r[0] ^ gen_r[1], gen_r[5:1]};
      prev_hist = hist;
      hist      = {c, hist[5:1]};
      exp_q.push_back(c ^ invert);
      for (int k = 0; k < HOLD; k++) begin
         valid_i = 1'b1;
         din     = c ^ invert ^ (glitch && k == 1);
         @(posedge clkin); #1;
      end
   endtask

   task automatic send_zero();
      exp_q.push_back(1'b0);
      for (int k = 0; k < HOLD; k++) begin
         valid_i = 1'b1;
         din     = 1'b0;
         @(posedge clkin); #1;
      end
   endtask

   task automatic relock_check(input string tag);
      repeat (14) send_chip(1'b0, 1'b0);
      chk({tag, "_early"}, {31'b0, lock_o}, 32'd0);
      send_chip(1'b0, 1'b0);
      chk({tag, "_lock"}, {31'b0, lock_o}, 32'd1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int e0;
      logic [5:0] p0;
      rst     = 1'b1;
      valid_i = 1'b0;
      din     = 1'b0;
      repeat (2) @(posedge clkin);
      @(negedge clkin);
      chk("rst_lock",   {31'b0, lock_o},        32'd0);
      chk("rst_chip",   {31'b0, chip_o},        32'd0);
      chk("rst_strobe", {31'b0, chip_strobe_o}, 32'd0);
      chk("rst_err",    {31'b0, err_o},         32'd0);
      chk("rst_phase",  {26'b0, phase_o},       32'd0);
      @(posedge clkin); #1;
      rst = 1'b0;

      // Acquisition from phase 101010: 6 fill + 8 verify chips
      repeat (13) send_chip(1'b0, 1'b0);
      chk("acq_lock13", {31'b0, lock_o}, 32'd0);
      send_chip(1'b0, 1'b0);
      chk("acq_lock14_pending", {31'b0, lock_o}, 32'd0);
      chk("acq_no_err", err_seen, 32'd0);
      send_chip(1'b0, 1'b0);
      chk("acq_lock", {31'b0, lock_o}, 32'd1);
      chk("acq_phase", {26'b0, phase_o}, {26'b0, prev_hist});

      // Single-sample glitch is voted away
      e0 = err_seen;
      send_chip(1'b0, 1'b1);
      send_chip(1'b0, 1'b0);
      chk("glitch_err", err_seen - e0, 32'd0);
      chk("glitch_lock", {31'b0, lock_o}, 32'd1);

      // Flywheel period
      p0 = phase_o;
      repeat (63) send_chip(1'b0, 1'b0);
      chk("period1", {26'b0, phase_o}, {26'b0, p0});
      chk("period1_hist", {26'b0, phase_o}, {26'b0, prev_hist});
      repeat (63) send_chip(1'b0, 1'b0);
      chk("period2", {26'b0, phase_o}, {26'b0, p0});

      // Two inverted chips: errors but lock holds
      e0 = err_seen;
      send_chip(1'b1, 1'b0);
      send_chip(1'b1, 1'b0);
      send_chip(1'b0, 1'b0);
      chk("inv2_err", err_seen - e0, 32'd2);
      chk("inv2_lock", {31'b0, lock_o}, 32'd1);
      chk("inv2_phase", {26'b0, phase_o}, {26'b0, prev_hist});

      // Three inverted chips: lock drops with a single pulse on the third
      e0 = err_seen;
      repeat (3) send_chip(1'b1, 1'b0);
      send_chip(1'b0, 1'b0);
      chk("inv3_err", err_seen - e0, 32'd3);
      chk("inv3_lock", {31'b0, lock_o}, 32'd0);
      repeat (13) send_chip(1'b0, 1'b0);
      chk("inv3_refill", {31'b0, lock_o}, 32'd0);
      send_chip(1'b0, 1'b0);
      chk("inv3_relock", {31'b0, lock_o}, 32'd1);

      // One-cycle valid drop
      valid_i = 1'b0;
      @(posedge clkin); #1;
      chk("drop_lock", {31'b0, lock_o}, 32'd0);
      chk("drop_strobe", {31'b0, chip_strobe_o}, 32'd0);
      relock_check("drop");

      // Reset pulse while locked
      @(negedge clkin); #1;
      rst = 1'b1;
      #1;
      chk("rstmid_lock", {31'b0, lock_o}, 32'd0);
      chk("rstmid_phase", {26'b0, phase_o}, 32'd0);
      @(posedge clkin); #1;
      rst = 1'b0;
      relock_check("rstmid");

      // All-zero stream never leaves FILL
      valid_i = 1'b0;
      @(posedge clkin); #1;
      e0 = err_seen;
      repeat (30) send_zero();
      chk("zero_lock", {31'b0, lock_o}, 32'd0);
      chk("zero_err", err_seen - e0, 32'd0);

      valid_i = 1'b0;
      repeat (3) @(posedge clkin);
      #1;
      chk("queue_drain", exp_q.size(), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule : tb_m_sequence_rx
`default_nettype wire
